// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and one-at-a-time transmit scheduler feeding the UART transmitter
module uart_tx_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk50M,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              busy,
    output logic              tx_trig,
    output logic [7:0]        tx_data,
    input  logic              tx_idle
);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];
    localparam logic [15:0]     GAP_LAST  = 16'(GAP_CYCLES - 1);

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [15:0]       gap_cnt;
    logic              push;
    logic              pop;
    logic [ADDR_W:0]   count_next;

    assign push = wr_en && !full;
    assign pop  = (state == IDLE) && !empty && tx_idle;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // Storage is deliberately left out of reset; only pointers and count define validity.
    always_ff @(posedge clk50M) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            busy     <= 1'b0;
            tx_trig  <= 1'b0;
            tx_data  <= 8'h00;
            gap_cnt  <= '0;
            state    <= IDLE;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == DEPTH_CNT);
            empty <= (count_next == '0);

            // A fresh overflow outranks a same-cycle clear.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end

            busy    <= (state != IDLE) || !empty;
            tx_trig <= 1'b0;

            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data <= mem[rd_ptr];
                        tx_trig <= 1'b1;
                        state   <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (!tx_idle) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_idle) begin
                        state <= (GAP_CYCLES > 0) ? GAP : IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo against a queue-based reference model
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int GAP    = 0;
    localparam int GGAP   = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              ovf_clr;
    logic              tx_idle;
    logic              full, empty, overflow, busy, tx_trig;
    logic [ADDR_W:0]   count;
    logic [7:0]        tx_data;

    logic              g_wr_en;
    logic [7:0]        g_wr_data;
    logic              g_ovf_clr;
    logic              g_tx_idle;
    logic              g_full, g_empty, g_overflow, g_busy, g_tx_trig;
    logic [ADDR_W:0]   g_count;
    logic [7:0]        g_tx_data;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP)) dut (
        .clk50M(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .ovf_clr(ovf_clr), .busy(busy), .tx_trig(tx_trig), .tx_data(tx_data),
        .tx_idle(tx_idle)
    );

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(GGAP)) dut_gap (
        .clk50M(clk), .rst(rst), .wr_en(g_wr_en), .wr_data(g_wr_data),
        .full(g_full), .empty(g_empty), .count(g_count), .overflow(g_overflow),
        .ovf_clr(g_ovf_clr), .busy(g_busy), .tx_trig(g_tx_trig), .tx_data(g_tx_data),
        .tx_idle(g_tx_idle)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: byte queue plus "scheduler may trigger from edge m_ready_at on".
    logic [7:0] q[$];
    bit         m_ovf, m_busy, m_trig, m_wait_fall, m_wait_rise;
    logic [7:0] m_data;
    int         m_ready_at;
    int         cyc;
    int         frame_len;
    int         tx_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_busy = 0; m_trig = 0; m_data = 8'h00;
        m_wait_fall = 0; m_wait_rise = 0;
        m_ready_at = cyc;
    endtask

    task automatic step();
        bit ready_pre, push_ok, pop_ok, trig_pre;
        ready_pre = !m_wait_fall && !m_wait_rise && (cyc >= m_ready_at);
        push_ok   = wr_en && (q.size() < DEPTH);
        if (wr_en && q.size() == DEPTH) m_ovf = 1;
        else if (ovf_clr)               m_ovf = 0;
        m_busy = !ready_pre || (q.size() != 0);
        if (m_wait_fall && !tx_idle) begin
            m_wait_fall = 0;
            m_wait_rise = 1;
        end else if (m_wait_rise && tx_idle) begin
            m_wait_rise = 0;
            m_ready_at  = cyc + 1 + GAP;
        end
        pop_ok = ready_pre && (q.size() != 0) && tx_idle;
        m_trig = pop_ok;
        if (pop_ok) begin
            m_data = q.pop_front();
            m_wait_fall = 1;
        end
        if (push_ok) q.push_back(wr_data);
        trig_pre = tx_trig;

        @(posedge clk);
        cyc++;
        #1;
        chk("trig", tx_trig, m_trig);
        chk("data", tx_data, m_data);
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("overflow", overflow, m_ovf);
        chk("busy", busy, m_busy);

        // Transmitter model: drops idle the edge after it samples the trigger.
        if (trig_pre) begin
            tx_idle = 1'b0;
            tx_left = frame_len;
        end else if (!tx_idle) begin
            if (tx_left <= 1) tx_idle = 1'b1;
            else              tx_left--;
        end
    endtask

    task automatic drain();
        wr_en = 1'b0;
        ovf_clr = 1'b0;
        for (int i = 0; i < 4000 && (q.size() != 0 || m_busy || !tx_idle); i++) step();
        step();
        chk("drain_count", count, 0);
        chk("drain_busy", busy, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0; tx_idle = 1'b1;
        g_wr_en = 1'b0; g_wr_data = 8'h00; g_ovf_clr = 1'b0; g_tx_idle = 1'b1;
        frame_len = 4; tx_left = 0; cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trig", tx_trig, 0);
        chk("rst_data", tx_data, 8'h00);
        rst = 1'b0;
        model_reset();

        // Single byte: empty falls after the write edge, trigger one edge later.
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        chk("a5_empty", empty, 0);
        chk("a5_count", count, 1);
        step();
        chk("a5_trig", tx_trig, 1);
        chk("a5_data", tx_data, 8'hA5);
        step();
        chk("a5_trig_low", tx_trig, 0);
        for (int i = 0; i < 50 && !tx_idle; i++) step();
        step();
        chk("a5_busy_hold", busy, 1);
        step();
        chk("a5_busy_fall", busy, 0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (tx_trig) n++;
        end
        chk("a5_no_second", n, 0);

        // Burst with a slow transmitter to fill the FIFO, then overflow handling.
        frame_len = 40;
        for (int i = 1; i <= 19; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 16);
        chk("ovf_full", full, 1);
        ovf_clr = 1'b1;
        step();
        chk("ovf_cleared", overflow, 0);
        wr_en = 1'b1; wr_data = 8'hEE;
        step();
        chk("ovf_clr_loses", overflow, 1);
        ovf_clr = 1'b0;

        // Continuous writes so pops coincide with pushes at full and pointers wrap.
        frame_len = 5;
        for (int i = 0; i < 200; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i);
            step();
        end
        drain();

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            wr_en     = ($urandom_range(0, 99) < 45);
            wr_data   = 8'($urandom);
            ovf_clr   = ($urandom_range(0, 99) < 5);
            frame_len = $urandom_range(1, 25);
            step();
        end
        drain();

        // Reset while waiting for the transmitter with bytes still queued.
        frame_len = 30;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hB0 + i);
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("mid_count", count, 3);
        #1 rst = 1'b1;
        #1;
        chk("mr_full", full, 0);
        chk("mr_empty", empty, 1);
        chk("mr_count", count, 0);
        chk("mr_overflow", overflow, 0);
        chk("mr_busy", busy, 0);
        chk("mr_trig", tx_trig, 0);
        chk("mr_data", tx_data, 8'h00);
        @(posedge clk);
        cyc++;
        #1 rst = 1'b0;
        model_reset();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tx_trig) n++;
        end
        chk("mr_no_trig", n, 0);
        wr_en = 1'b1; wr_data = 8'h5C;
        step();
        drain();

        // Gap instance: next trigger lands GGAP+1 edges after the edge that first samples tx_idle high.
        g_wr_en = 1'b1; g_wr_data = 8'h3C;
        @(posedge clk); #1;
        g_wr_data = 8'hC3;
        @(posedge clk); #1;
        g_wr_en = 1'b0;
        n = 0;
        while (!g_tx_trig && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("gap_first_trig", g_tx_trig, 1);
        chk("gap_first_data", g_tx_data, 8'h3C);
        @(posedge clk); #1;
        g_tx_idle = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        g_tx_idle = 1'b1;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            n++;
            if (g_tx_trig) break;
        end
        chk("gap_latency", n, GGAP + 2);
        chk("gap_second_data", g_tx_data, 8'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
